fetch_step_ctrl: RTL and testbench
==================================

Name: fetch_step_ctrl

Overview:
Parametrised fetch/sequencing controller that replaces the debounced-pushbutton gated clock with a single free-running clock plus clock-enables. It holds the PC and addresses the instruction memory. It waits a configurable read latency, latches the instruction, and issues a one-cycle exec_en strobe that qualifies regfile/data-memory writes downstream. It supports halt, single-step, free-run and PC breakpoint modes.

Parameters:
PC_W, 9, program counter / instruction memory address width
INSTR_W, 16, instruction width
OFFSET_W, 9, branch offset width (two's complement, in instructions)
MEM_LAT, 1, instruction memory read latency in cycles, legal 0..3

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
step_pulse  in  1  one-cycle pulse from debounced step button
run  in  1  level; 1 = free-run mode
halt_req  in  1  pulse; request stop after current instruction
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
take_branch  in  1  from ALU, sampled only in EXEC
offset  in  OFFSET_W  branch offset from mapper, sampled only in EXEC
imem_addr  out  PC_W  instruction memory address (= pc)
imem_rdata  in  INSTR_W  instruction memory data
instr  out  INSTR_W  latched instruction
instr_valid  out  1  instr holds a fetched, not-yet-superseded instruction
exec_en  out  1  one-cycle commit strobe
pc  out  PC_W  current PC
state  out  2  FSM state encoding
halted  out  1  1 in HALT
bp_hit  out  1  sticky; set when a breakpoint stopped execution
retired_cnt  out  16  instructions retired

Behaviour:
- Reset (reset==0 at posedge): state=HALT, pc=0, instr=0, instr_valid=0, exec_en=0, bp_hit=0, retired_cnt=0, halt_pending=0, wait counter=0. Reset overrides every in-flight operation on the same edge; no exec_en is issued.
- State encoding: HALT=2'b00, FETCH=2'b01, WAIT=2'b10, EXEC=2'b11.
- HALT:
  - run==1 → FETCH; clear bp_hit.
  - Else step_pulse==1 → FETCH with step_mode=1.
  - Otherwise stay. halted=1 only in this state.
- FETCH:
  - imem_addr=pc; instr_valid=0.
  - MEM_LAT==0: latch imem_rdata into instr this edge → EXEC.
  - MEM_LAT>0: load wait counter with MEM_LAT-1 → WAIT.
- WAIT: decrement counter. At 0, latch imem_rdata → EXEC. imem_addr stays stable throughout.
- EXEC:
  - exec_en=1 for exactly this cycle; instr_valid=1.
  - next_pc = take_branch ? pc + sign_extend(offset) : pc + 1, truncated to PC_W (wraps, e.g. 511+1 → 0 for PC_W=9).
  - retired_cnt += 1, saturating at 16'hFFFF.
- EXEC next state, in priority order:
  1. halt_pending, step_mode, or run==0 → HALT.
  2. bp_en && next_pc==bp_addr → HALT, bp_hit=1.
  3. Otherwise → FETCH.
  - Clear step_mode and halt_pending on leaving EXEC.
- Latency: MEM_LAT+2 cycles per instruction (FETCH, MEM_LAT×WAIT, EXEC); for MEM_LAT=0, 2 cycles.
- halt_req in any non-HALT state sets halt_pending. The in-flight instruction always completes; there is no mid-instruction abort. halt_req in HALT is ignored.
- step_pulse outside HALT is ignored, not queued.
- Breakpoint is checked only on EXEC→FETCH. Resuming from HALT with pc==bp_addr executes that instruction, so execution never deadlocks on its own breakpoint.
- run deasserted during FETCH/WAIT: the current instruction still completes, then HALT.
- instr_valid remains 1 in HALT after EXEC, so the display/debug path shows the last instruction.

Optional Feature:
BRANCH_CNT_EN:
- Defined: adds output branch_cnt[15:0]. Reset 0; increments in EXEC when take_branch==1; saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, MEM_LAT=1, imem[0]=16'h1234, pulse step_pulse once → state HALT→FETCH→WAIT→EXEC→HALT. exec_en high exactly 1 cycle, instr=16'h1234, pc=1, retired_cnt=1.
- run=1, no branches, 5 instructions → exec_en every 3rd cycle. Drop run → stop after current EXEC; retired_cnt equals exec_en count.
- pc=10, take_branch=1, offset=9'h1FD (−3) in EXEC → pc=7. pc=511, take_branch=0 → pc=0 (wrap).
- bp_en=1, bp_addr=4, run=1 from pc=0 → HALT with pc=4, bp_hit=1, retired_cnt=4. Toggle run → instruction at 4 executes, pc=5, bp_hit cleared.
- halt_req during WAIT → that instruction commits (one exec_en), then HALT. step_pulse during FETCH → ignored, no second instruction.
- Drive reset=0 in WAIT → next edge state=HALT, pc=0, exec_en never asserted. With BRANCH_CNT_EN: 3 taken branches → branch_cnt=3.

Source files
------------

// File: rtl/fetch_step_ctrl.sv
// rtl/fetch_step_ctrl.sv - fetch/sequencing controller with clock-enable commit strobe
// Optional feature macro: BRANCH_CNT_EN adds the saturating branch_cnt output.
module fetch_step_ctrl #(
   parameter int PC_W     = 9,
   parameter int INSTR_W  = 16,
   parameter int OFFSET_W = 9,
   parameter int MEM_LAT  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                step_pulse,
   input  logic                run,
   input  logic                halt_req,
   input  logic                bp_en,
   input  logic [PC_W-1:0]     bp_addr,
   input  logic                take_branch,
   input  logic [OFFSET_W-1:0] offset,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  instr,
   output logic                instr_valid,
   output logic                exec_en,
   output logic [PC_W-1:0]     pc,
   output logic [1:0]          state,
   output logic                halted,
   output logic                bp_hit,
`ifdef BRANCH_CNT_EN
   output logic [15:0]         branch_cnt,
`endif
   output logic [15:0]         retired_cnt
);

   typedef enum logic [1:0] {
      S_HALT  = 2'b00,
      S_FETCH = 2'b01,
      S_WAIT  = 2'b10,
      S_EXEC  = 2'b11
   } state_t;

   localparam logic [1:0] WAIT_INIT = (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic                instr_valid_q, instr_valid_d;
   logic                bp_hit_q, bp_hit_d;
   logic [15:0]         retired_q, retired_d;
   logic                halt_pending_q, halt_pending_d;
   logic                step_mode_q, step_mode_d;
   logic [1:0]          wait_cnt_q, wait_cnt_d;
   logic [PC_W-1:0]     offset_ext;
   logic [PC_W-1:0]     next_pc;
`ifdef BRANCH_CNT_EN
   logic [15:0]         branch_cnt_q, branch_cnt_d;
`endif

   assign offset_ext = PC_W'($signed(offset));
   assign next_pc    = take_branch ? (pc_q + offset_ext) : (pc_q + 1'b1);

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      instr_d        = instr_q;
      instr_valid_d  = instr_valid_q;
      bp_hit_d       = bp_hit_q;
      retired_d      = retired_q;
      halt_pending_d = halt_pending_q;
      step_mode_d    = step_mode_q;
      wait_cnt_d     = wait_cnt_q;
      exec_en        = 1'b0;
`ifdef BRANCH_CNT_EN
      branch_cnt_d   = branch_cnt_q;
`endif

      if (halt_req && (state_q == S_FETCH || state_q == S_WAIT)) begin
         halt_pending_d = 1'b1;
      end

      case (state_q)
         S_HALT: begin
            if (run) begin
               state_d       = S_FETCH;
               bp_hit_d      = 1'b0;
               step_mode_d   = 1'b0;
               instr_valid_d = 1'b0;
            end else if (step_pulse) begin
               state_d       = S_FETCH;
               step_mode_d   = 1'b1;
               instr_valid_d = 1'b0;
            end
         end
         S_FETCH: begin
            if (MEM_LAT == 0) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = S_EXEC;
            end else begin
               wait_cnt_d = WAIT_INIT;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = S_EXEC;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         S_EXEC: begin
            exec_en        = 1'b1;
            pc_d           = next_pc;
            halt_pending_d = 1'b0;
            step_mode_d    = 1'b0;
            if (retired_q != 16'hFFFF) begin
               retired_d = retired_q + 16'd1;
            end
`ifdef BRANCH_CNT_EN
            if (take_branch && branch_cnt_q != 16'hFFFF) begin
               branch_cnt_d = branch_cnt_q + 16'd1;
            end
`endif
            // A halt_req landing in EXEC still stops after this instruction.
            if (halt_pending_q || halt_req || step_mode_q || !run) begin
               state_d = S_HALT;
            end else if (bp_en && next_pc == bp_addr) begin
               state_d  = S_HALT;
               bp_hit_d = 1'b1;
            end else begin
               state_d       = S_FETCH;
               instr_valid_d = 1'b0;
            end
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_HALT;
         pc_q           <= '0;
         instr_q        <= '0;
         instr_valid_q  <= 1'b0;
         bp_hit_q       <= 1'b0;
         retired_q      <= '0;
         halt_pending_q <= 1'b0;
         step_mode_q    <= 1'b0;
         wait_cnt_q     <= '0;
`ifdef BRANCH_CNT_EN
         branch_cnt_q   <= '0;
`endif
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         instr_valid_q  <= instr_valid_d;
         bp_hit_q       <= bp_hit_d;
         retired_q      <= retired_d;
         halt_pending_q <= halt_pending_d;
         step_mode_q    <= step_mode_d;
         wait_cnt_q     <= wait_cnt_d;
`ifdef BRANCH_CNT_EN
         branch_cnt_q   <= branch_cnt_d;
`endif
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign state       = state_q;
   assign halted      = (state_q == S_HALT);
   assign bp_hit      = bp_hit_q;
   assign retired_cnt = retired_q;
`ifdef BRANCH_CNT_EN
   assign branch_cnt  = branch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_step_ctrl.sv
// tb/tb_fetch_step_ctrl.sv - self-checking bench for fetch_step_ctrl (MEM_LAT=1)
module tb_fetch_step_ctrl;

   logic        clk;
   logic        reset;
   logic        step_pulse;
   logic        run;
   logic        halt_req;
   logic        bp_en;
   logic [8:0]  bp_addr;
   logic        take_branch;
   logic [8:0]  offset;
   logic [8:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic        exec_en;
   logic [8:0]  pc;
   logic [1:0]  state;
   logic        halted;
   logic        bp_hit;
   logic [15:0] retired_cnt;
`ifdef BRANCH_CNT_EN
   logic [15:0] branch_cnt;
`endif

   fetch_step_ctrl #(.PC_W(9), .INSTR_W(16), .OFFSET_W(9), .MEM_LAT(1)) dut (
      .clk(clk), .reset(reset), .step_pulse(step_pulse), .run(run),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
      .take_branch(take_branch), .offset(offset), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
      .exec_en(exec_en), .pc(pc), .state(state), .halted(halted),
      .bp_hit(bp_hit),
`ifdef BRANCH_CNT_EN
      .branch_cnt(branch_cnt),
`endif
      .retired_cnt(retired_cnt)
   );

   typedef struct {
      logic [8:0]  pc;
      logic [15:0] instr;
   } exp_t;

   typedef struct {
      logic       tb;
      logic [8:0] off;
      logic [8:0] exp_pc;
   } br_vec_t;

   exp_t    exp_q[$];
   br_vec_t vecs[8];
   int      checks;
   int      failures;
   int      exec_cnt;

   function automatic logic [15:0] mem_word(input logic [8:0] a);
      return (a == 9'd0) ? 16'h1234 : {7'h60, a};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one-cycle read latency instruction memory
   always @(posedge clk) imem_rdata <= mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && exec_en) begin
         exec_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_exec", {23'd0, pc}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_pc", {23'd0, pc}, {23'd0, e.pc});
            check("sb_instr", {16'd0, instr}, {16'd0, e.instr});
            check("sb_valid", {31'd0, instr_valid}, 32'd1);
         end
      end
   end

   task automatic wait_halt();
      int n;
      n = 0;
      @(negedge clk);
      while (!halted && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!halted) check("halt_timeout", {31'd0, halted}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int last;
      int n_ex;
      int m_pc;
      int taken;
      int ex0;

      vecs[0] = '{tb: 1'b1, off: 9'h004, exp_pc: 9'd10};
      vecs[1] = '{tb: 1'b1, off: 9'h1FD, exp_pc: 9'd7};
      vecs[2] = '{tb: 1'b1, off: 9'h0F8, exp_pc: 9'd255};
      vecs[3] = '{tb: 1'b1, off: 9'h0FF, exp_pc: 9'd510};
      vecs[4] = '{tb: 1'b0, off: 9'h1FD, exp_pc: 9'd511};
      vecs[5] = '{tb: 1'b0, off: 9'h000, exp_pc: 9'd0};
      vecs[6] = '{tb: 1'b1, off: 9'h100, exp_pc: 9'd256};
      vecs[7] = '{tb: 1'b1, off: 9'h100, exp_pc: 9'd0};

      checks = 0; failures = 0; exec_cnt = 0;
      reset = 1'b0; step_pulse = 1'b0; run = 1'b0; halt_req = 1'b0;
      bp_en = 1'b0; bp_addr = 9'd0; take_branch = 1'b0; offset = 9'd0;

      do_reset();
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_pc", {23'd0, pc}, 32'd0);
      check("rst_instr", {16'd0, instr}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_exec", {31'd0, exec_en}, 32'd0);
      check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
      check("rst_retired", {16'd0, retired_cnt}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd1);

      // single step with an ignored step_pulse during FETCH
      exp_q.push_back('{pc: 9'd0, instr: 16'h1234});
      step_pulse = 1'b1;
      @(negedge clk); step_pulse = 1'b0;
      check("step_fetch", {30'd0, state}, 32'd1);
      check("step_fetch_valid", {31'd0, instr_valid}, 32'd0);
      step_pulse = 1'b1;
      @(negedge clk); step_pulse = 1'b0;
      check("step_wait", {30'd0, state}, 32'd2);
      @(negedge clk);
      check("step_exec", {30'd0, state}, 32'd3);
      check("step_exec_en", {31'd0, exec_en}, 32'd1);
      @(negedge clk);
      check("step_halt", {30'd0, state}, 32'd0);
      check("step_pc", {23'd0, pc}, 32'd1);
      check("step_instr", {16'd0, instr}, 32'h1234);
      check("step_retired", {16'd0, retired_cnt}, 32'd1);
      check("step_valid_kept", {31'd0, instr_valid}, 32'd1);
      repeat (4) @(negedge clk);
      check("step_no_second", exec_cnt, 32'd1);
      check("step_still_halt", {30'd0, state}, 32'd0);

      // free run: five instructions, exec_en every third cycle
      for (int p = 1; p <= 5; p++) exp_q.push_back('{pc: 9'(p), instr: mem_word(9'(p))});
      run = 1'b1; last = -1; n_ex = 0;
      for (int cyc = 0; cyc < 40 && n_ex < 5; cyc++) begin
         @(negedge clk);
         if (exec_en) begin
            if (last >= 0) check("run_spacing", cyc - last, 32'd3);
            last = cyc;
            n_ex++;
            if (n_ex == 5) run = 1'b0;
         end
      end
      check("run_count", n_ex, 32'd5);
      wait_halt();
      check("run_pc", {23'd0, pc}, 32'd6);
      check("run_retired", {16'd0, retired_cnt}, 32'd6);
      check("run_exec_match", exec_cnt, {16'd0, retired_cnt});

      // branch vectors applied by single-stepping
      m_pc = 6; taken = 0;
      foreach (vecs[i]) begin
         take_branch = vecs[i].tb;
         offset      = vecs[i].off;
         exp_q.push_back('{pc: 9'(m_pc), instr: mem_word(9'(m_pc))});
         step_pulse = 1'b1;
         @(negedge clk); step_pulse = 1'b0;
         wait_halt();
         check($sformatf("br_pc_%0d", i), {23'd0, pc}, {23'd0, vecs[i].exp_pc});
         m_pc = int'(vecs[i].exp_pc);
         if (vecs[i].tb) taken++;
      end
      take_branch = 1'b0; offset = 9'd0;
      check("br_retired", {16'd0, retired_cnt}, 32'd14);
`ifdef BRANCH_CNT_EN
      check("branch_cnt", {16'd0, branch_cnt}, taken);
`endif

      // breakpoint at 4, then resume over it
      do_reset();
      bp_en = 1'b1; bp_addr = 9'd4;
      for (int p = 0; p < 4; p++) exp_q.push_back('{pc: 9'(p), instr: mem_word(9'(p))});
      run = 1'b1;
      wait_halt();
      run = 1'b0;
      check("bp_pc", {23'd0, pc}, 32'd4);
      check("bp_hit", {31'd0, bp_hit}, 32'd1);
      check("bp_retired", {16'd0, retired_cnt}, 32'd4);
      exp_q.push_back('{pc: 9'd4, instr: mem_word(9'd4)});
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      check("bp_resume_cleared", {31'd0, bp_hit}, 32'd0);
      wait_halt();
      check("bp_resume_pc", {23'd0, pc}, 32'd5);
      check("bp_resume_retired", {16'd0, retired_cnt}, 32'd5);
      bp_en = 1'b0;

      // halt_req during WAIT with run held high
      exp_q.push_back('{pc: 9'd5, instr: mem_word(9'd5)});
      ex0 = exec_cnt;
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("hr_in_wait", {30'd0, state}, 32'd2);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      wait_halt();
      run = 1'b0;
      check("hr_pc", {23'd0, pc}, 32'd6);
      check("hr_one_exec", exec_cnt - ex0, 32'd1);

      // reset asserted during WAIT aborts with no commit
      ex0 = exec_cnt;
      step_pulse = 1'b1;
      @(negedge clk); step_pulse = 1'b0;
      @(negedge clk);
      check("rw_in_wait", {30'd0, state}, 32'd2);
      reset = 1'b0;
      @(negedge clk);
      check("rw_state", {30'd0, state}, 32'd0);
      check("rw_pc", {23'd0, pc}, 32'd0);
      check("rw_exec_en", {31'd0, exec_en}, 32'd0);
      check("rw_retired", {16'd0, retired_cnt}, 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rw_no_exec", exec_cnt - ex0, 32'd0);
      check("sb_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
